// File: rtl/br_fifo_shared_pstatic_pop_merge_pkg.sv
// Shared types and helpers for the shared pseudo-static multi-FIFO pop merge.
package br_fifo_shared_pstatic_pop_merge_pkg;

  typedef enum logic [1:0] {
    Empty = 2'd0,
    One   = 2'd1,
    Two   = 2'd2
  } state_t;

  function automatic int clamped_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/br_fifo_shared_pstatic_pop_merge_rr_arb.sv
// Round-robin arbiter across per-FIFO pop requests; owns the last_grant pointer.
module br_fifo_shared_pstatic_pop_merge_rr_arb
  import br_fifo_shared_pstatic_pop_merge_pkg::*;
#(
  parameter int NumFifos = 2,
  parameter int IdWidth  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NumFifos-1:0] req,
  input  logic                en,
  output logic [NumFifos-1:0] grant,
  output logic [IdWidth-1:0]  grant_idx
);

  logic [IdWidth-1:0] last_grant;
  logic [IdWidth-1:0] idx;
  logic               found;

  // Search starts one past the last winner so the previous winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 1; k <= NumFifos; k++) begin
      idx = IdWidth'((int'(last_grant) + k) % NumFifos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IdWidth'(NumFifos - 1);
    end else if (en && found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/br_fifo_shared_pstatic_pop_merge.sv
// Merges per-FIFO pop interfaces into one ID-tagged stream through a 2-entry output stage.
// Optional saturating per-FIFO grant counters: BR_FIFO_SHARED_PSTATIC_POP_MERGE_STATS_EN.
module br_fifo_shared_pstatic_pop_merge
  import br_fifo_shared_pstatic_pop_merge_pkg::*;
#(
  parameter int  NumFifos    = 2,
  parameter int  Width       = 1,
  parameter int  CountWidth  = 16,
  localparam int FifoIdWidth = clamped_clog2(NumFifos)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumFifos-1:0]            in_valid,
  output logic [NumFifos-1:0]            in_ready,
  input  logic [NumFifos*Width-1:0]      in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [Width-1:0]               out_data,
  output logic [FifoIdWidth-1:0]         out_fifo_id,
  output logic [NumFifos*CountWidth-1:0] grant_count
);

  state_t                 state, state_nxt;
  logic                   skid_valid;
  logic                   can_accept;
  logic                   accept;
  logic                   pop;
  logic                   load_main;
  logic                   load_skid;
  logic                   skid_to_main;
  logic [NumFifos-1:0]    grant;
  logic [FifoIdWidth-1:0] grant_idx;
  logic [Width-1:0]       sel_data;
  logic [Width-1:0]       main_data;
  logic [Width-1:0]       skid_data;
  logic [FifoIdWidth-1:0] main_id;
  logic [FifoIdWidth-1:0] skid_id;

  br_fifo_shared_pstatic_pop_merge_rr_arb #(
    .NumFifos(NumFifos),
    .IdWidth (FifoIdWidth)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (in_valid),
    .en       (can_accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign skid_valid = (state == Two);
  assign can_accept = !skid_valid;
  assign in_ready   = grant & {NumFifos{can_accept & !rst}};
  assign accept     = |in_ready;
  assign out_valid  = (state != Empty);
  assign pop        = out_valid & out_ready;
  assign out_data   = main_data;
  assign out_fifo_id = main_id;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NumFifos; i++) begin
      if (grant[i]) sel_data = in_data[i*Width +: Width];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= Empty;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      Empty: begin
        if (accept) begin
          load_main = 1'b1;
          state_nxt = One;
        end
      end
      One: begin
        if (pop) begin
          if (accept) load_main = 1'b1;
          else        state_nxt = Empty;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = Two;
        end
      end
      Two: begin
        if (pop) begin
          skid_to_main = 1'b1;
          state_nxt    = One;
        end
      end
      default: state_nxt = Empty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_id   <= '0;
      skid_data <= '0;
      skid_id   <= '0;
    end else begin
      if (load_main) begin
        main_data <= sel_data;
        main_id   <= grant_idx;
      end else if (skid_to_main) begin
        main_data <= skid_data;
        main_id   <= skid_id;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_id   <= grant_idx;
      end
    end
  end

`ifdef BR_FIFO_SHARED_PSTATIC_POP_MERGE_STATS_EN
  for (genvar i = 0; i < NumFifos; i++) begin : g_cnt
    logic [CountWidth-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (in_ready[i] && !(&cnt)) begin
        cnt <= cnt + CountWidth'(1);
      end
    end
    assign grant_count[i*CountWidth +: CountWidth] = cnt;
  end
`else
  assign grant_count = '0;
`endif

endmodule
